// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_CH byte streams.
// A grant is held for a whole packet (until a last byte) or until the lock idles out.
module uart_tx_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int CH_BITS      = 2,
    parameter int DATA_BITS    = 8,
    parameter int LOCK_TIMEOUT = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH*DATA_BITS-1:0] req_data,
    input  logic [NUM_CH-1:0]           req_last,
    output logic [NUM_CH-1:0]           req_ready,
    output logic                        tx_start,
    output logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_done_tick,
    output logic                        busy,
    output logic [CH_BITS-1:0]          grant_ch,
    output logic [1:0]                  dbg_state
);

    localparam int TMR_BITS = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [CH_BITS:0] NUM_CH_W = (CH_BITS + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_HOLD      = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CH_BITS-1:0]    last_ch_q, last_ch_d;
    logic [CH_BITS-1:0]    grant_ch_q, grant_ch_d;
    logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
    logic                  last_reg_q, last_reg_d;
    logic                  busy_q, busy_d;
    logic [TMR_BITS-1:0]   timer_q, timer_d;

    logic [DATA_BITS-1:0]  ch_data [NUM_CH];
    logic                  pick_found;
    logic [CH_BITS-1:0]    pick_ch;
    logic [CH_BITS:0]      cand;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_data[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    // Scan from the farthest offset down so the nearest valid channel after last_ch wins.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        cand       = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = {1'b0, last_ch_q} + (CH_BITS + 1)'(i);
            if (cand >= NUM_CH_W) begin
                cand = cand - NUM_CH_W;
            end
            if (req_valid[cand[CH_BITS-1:0]]) begin
                pick_found = 1'b1;
                pick_ch    = cand[CH_BITS-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_ch_d  = last_ch_q;
        grant_ch_d = grant_ch_q;
        tx_data_d  = tx_data_q;
        last_reg_d = last_reg_q;
        busy_d     = busy_q;
        timer_d    = timer_q;
        req_ready  = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found && !reset) begin
                    req_ready[pick_ch] = 1'b1;
                    tx_data_d          = ch_data[pick_ch];
                    last_reg_d         = req_last[pick_ch];
                    grant_ch_d         = pick_ch;
                    busy_d             = 1'b1;
                    state_d            = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_done_tick) begin
                    if (last_reg_q) begin
                        last_ch_d = grant_ch_q;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A byte from the lock owner beats the timeout on the same cycle.
                if (req_valid[grant_ch_q] && !reset) begin
                    req_ready[grant_ch_q] = 1'b1;
                    tx_data_d             = ch_data[grant_ch_q];
                    last_reg_d            = req_last[grant_ch_q];
                    state_d               = S_START;
                end else if (timer_q == TMR_LAST) begin
                    last_ch_d = grant_ch_q;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TMR_BITS'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_ch_q  <= CH_BITS'(NUM_CH - 1);
            grant_ch_q <= '0;
            tx_data_q  <= '0;
            last_reg_q <= 1'b0;
            busy_q     <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_ch_q  <= last_ch_d;
            grant_ch_q <= grant_ch_d;
            tx_data_q  <= tx_data_d;
            last_reg_q <= last_reg_d;
            busy_q     <= busy_d;
            timer_q    <= timer_d;
        end
    end

    assign tx_start  = (state_q == S_START) && !reset;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign grant_ch  = grant_ch_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO-like sources, a uart_tx stand-in, a packet-level
// reference model compared every cycle, and directed literal expectations.
module tb_uart_tx_arbiter;

    localparam int NUM_CH       = 4;
    localparam int CH_BITS      = 2;
    localparam int DATA_BITS    = 8;
    localparam int LOCK_TIMEOUT = 8;
    localparam int UART_LEN     = 3;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [NUM_CH-1:0]           req_valid = '0;
    logic [NUM_CH*DATA_BITS-1:0] req_data = '0;
    logic [NUM_CH-1:0]           req_last = '0;
    logic [NUM_CH-1:0]           req_ready;
    logic                        tx_start;
    logic [DATA_BITS-1:0]        tx_data;
    logic                        tx_done_tick = 1'b0;
    logic                        busy;
    logic [CH_BITS-1:0]          grant_ch;
    logic [1:0]                  dbg_state;

    uart_tx_arbiter #(
        .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .DATA_BITS(DATA_BITS), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done_tick(tx_done_tick), .busy(busy), .grant_ch(grant_ch), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Per-channel byte sources: {last, data}
    logic [8:0]        src_mem [NUM_CH][16];
    int                src_head [NUM_CH];
    int                src_tail [NUM_CH];
    logic [NUM_CH-1:0] src_en = '0;
    int                acc_ch = -1;
    bit                start_seen = 1'b0;
    int                uart_cnt = 0;

    logic [CH_BITS+DATA_BITS-1:0] exp_q[$];

    task automatic push(input int ch, input bit last, input logic [7:0] d);
        src_mem[ch][src_tail[ch]] = {last, d};
        src_tail[ch]++;
    endtask

    task automatic expect_tx(input int ch, input logic [7:0] d);
        exp_q.push_back({CH_BITS'(ch), d});
    endtask

    task automatic drive_src();
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_en[i] && src_head[i] < src_tail[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DATA_BITS +: DATA_BITS] = src_mem[i][src_head[i]][7:0];
                req_last[i] = src_mem[i][src_head[i]][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DATA_BITS +: DATA_BITS] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_ch >= 0) src_head[acc_ch]++;
        tx_done_tick = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) tx_done_tick = 1'b1;
        end
        if (start_seen) uart_cnt = UART_LEN;
        drive_src();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_en = '0;
        uart_cnt = 0;
        tx_done_tick = 1'b0;
        drive_src();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        exp_q.delete();
        drive_src();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!tx_done_tick && n < 50) begin
            step();
            n++;
        end
        #1;
        chk("wait_done", 32'(tx_done_tick), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            step();
            n++;
        end
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Reference model: who owns the transmitter and where the byte is in its life.
    int          m_owner = -1;
    int          m_ptr = NUM_CH - 1;
    int          m_grant = 0;
    int          m_gap = 0;
    int          m_acc = -1;
    bit          m_start_due = 1'b0;
    bit          m_on_wire = 1'b0;
    bit          m_last = 1'b0;
    logic [7:0]  m_data = '0;
    logic [NUM_CH-1:0] exp_rdy;
    logic [CH_BITS+DATA_BITS-1:0] sb_e;

    function automatic int first_valid(input int ptr, input logic [NUM_CH-1:0] v);
        int c;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (ptr + k) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        acc_ch = -1;
        start_seen = 1'b0;
        m_acc = -1;
        if (!reset) begin
            exp_rdy = '0;
            if (m_owner < 0) begin
                m_acc = first_valid(m_ptr, req_valid);
            end else if (!m_start_due && !m_on_wire && req_valid[m_owner]) begin
                m_acc = m_owner;
            end
            if (m_acc >= 0) exp_rdy[m_acc] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("tx_start", 32'(tx_start), 32'(m_start_due));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("grant_ch", 32'(grant_ch), 32'(m_grant));
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_valid[i] && req_ready[i]) acc_ch = i;
            end
            if (tx_start) begin
                start_seen = 1'b1;
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    chk("sb_ch", 32'(grant_ch), 32'(sb_e[CH_BITS+DATA_BITS-1:DATA_BITS]));
                    chk("sb_data", 32'(tx_data), 32'(sb_e[DATA_BITS-1:0]));
                end else begin
                    chk("sb_unexpected_start", 32'(tx_start), 32'd0);
                end
            end
        end
        if (reset) begin
            m_owner = -1; m_ptr = NUM_CH - 1; m_grant = 0; m_gap = 0;
            m_start_due = 1'b0; m_on_wire = 1'b0; m_last = 1'b0; m_data = '0;
        end else if (m_acc >= 0) begin
            m_owner = m_acc;
            m_grant = m_acc;
            m_data = req_data[m_acc*DATA_BITS +: DATA_BITS];
            m_last = req_last[m_acc];
            m_start_due = 1'b1;
            m_gap = 0;
        end else if (m_start_due) begin
            m_start_due = 1'b0;
            m_on_wire = 1'b1;
        end else if (m_on_wire) begin
            if (tx_done_tick) begin
                m_on_wire = 1'b0;
                if (m_last) begin
                    m_ptr = m_owner;
                    m_owner = -1;
                end
            end
        end else if (m_owner >= 0) begin
            m_gap++;
            if (m_gap == LOCK_TIMEOUT) begin
                m_ptr = m_owner;
                m_owner = -1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end

        // Single byte from ch2
        do_reset();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'(grant_ch), 32'd0);
        push(2, 1'b1, 8'hA5);
        expect_tx(2, 8'hA5);
        src_en = 4'b1111;
        drive_src();
        #1;
        chk("t1_ready_c0", 32'(req_ready), 32'h4);
        chk("t1_start_c0", 32'(tx_start), 32'd0);
        step();
        #1;
        chk("t1_start_c1", 32'(tx_start), 32'd1);
        chk("t1_data_c1", 32'(tx_data), 32'hA5);
        chk("t1_grant_c1", 32'(grant_ch), 32'd2);
        wait_done();
        chk("t1_busy_tick", 32'(busy), 32'd1);
        step();
        #1;
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_grant_after", 32'(grant_ch), 32'd2);
        drain("t1_drain");

        // Round robin, every byte last
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                push(c, 1'b1, 8'(c * 16 + k));
                expect_tx(c, 8'(c * 16 + k));
            end
        end
        src_en = 4'b1111;
        drive_src();
        #1;
        chk("t2_first_ready", 32'(req_ready), 32'h1);
        drain("t2_drain");

        // Packet lock on ch1 while ch0 and ch3 wait
        do_reset();
        push(1, 1'b0, 8'h11); push(1, 1'b0, 8'h22); push(1, 1'b1, 8'h33);
        push(0, 1'b1, 8'h0A); push(3, 1'b1, 8'h3C);
        expect_tx(1, 8'h11); expect_tx(1, 8'h22); expect_tx(1, 8'h33);
        expect_tx(3, 8'h3C); expect_tx(0, 8'h0A);
        src_en = 4'b0010;
        drive_src();
        #1;
        chk("t3_ready_c0", 32'(req_ready), 32'h2);
        step();
        src_en = 4'b1111;
        drive_src();
        wait_done();
        step();
        #1;
        chk("t3_hold_ready", 32'(req_ready), 32'h2);
        step();
        #1;
        chk("t3_hold_start", 32'(tx_start), 32'd1);
        chk("t3_hold_data", 32'(tx_data), 32'h22);
        drain("t3_drain");

        // Lock timeout: ch0 goes quiet after a non-last byte
        do_reset();
        push(0, 1'b0, 8'h55);
        push(1, 1'b1, 8'h77);
        expect_tx(0, 8'h55); expect_tx(1, 8'h77);
        src_en = 4'b0001;
        drive_src();
        step();
        src_en = 4'b0011;
        drive_src();
        wait_done();
        for (int k = 0; k < LOCK_TIMEOUT - 1; k++) step();
        step();
        #1;
        chk("t4_last_hold_busy", 32'(busy), 32'd1);
        chk("t4_last_hold_ready", 32'(req_ready), 32'd0);
        step();
        #1;
        chk("t4_release_busy", 32'(busy), 32'd0);
        chk("t4_release_ready", 32'(req_ready), 32'h2);
        drain("t4_drain");

        // Owner byte arrives on the timeout cycle
        do_reset();
        push(0, 1'b0, 8'h55);
        push(1, 1'b1, 8'h77);
        expect_tx(0, 8'h55); expect_tx(0, 8'h66); expect_tx(1, 8'h77);
        src_en = 4'b0001;
        drive_src();
        step();
        src_en = 4'b0011;
        drive_src();
        wait_done();
        for (int k = 0; k < LOCK_TIMEOUT - 1; k++) step();
        step();
        push(0, 1'b1, 8'h66);
        drive_src();
        #1;
        chk("t5_race_ready", 32'(req_ready), 32'h1);
        step();
        #1;
        chk("t5_race_start", 32'(tx_start), 32'd1);
        chk("t5_race_data", 32'(tx_data), 32'h66);
        chk("t5_race_grant", 32'(grant_ch), 32'd0);
        drain("t5_drain");

        // Reset while a byte is on the wire
        do_reset();
        push(0, 1'b0, 8'hAA); push(0, 1'b1, 8'hBB);
        push(2, 1'b1, 8'hC2);
        expect_tx(0, 8'hAA);
        src_en = 4'b0101;
        drive_src();
        step();
        step();
        #1;
        chk("t6_busy_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        src_en = '0;
        uart_cnt = 0;
        drive_src();
        step();
        reset = 1'b0;
        #1;
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_data", 32'(tx_data), 32'd0);
        chk("t6_rst_sb", 32'(exp_q.size()), 32'd0);
        tx_done_tick = 1'b1;
        step();
        #1;
        chk("t6_stray_busy", 32'(busy), 32'd0);
        chk("t6_stray_start", 32'(tx_start), 32'd0);
        expect_tx(0, 8'hBB); expect_tx(2, 8'hC2);
        src_en = 4'b0101;
        drive_src();
        #1;
        chk("t6_prio_ready", 32'(req_ready), 32'h1);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter among NUM_CH byte-stream requesters using round-robin arbitration with packet locking. A granted channel keeps the transmitter until it sends a byte marked last, or until a lock timeout expires. The block sits between per-channel FIFOs and the uart_tx instance. It drives tx_start and data_in, and consumes tx_done_tick.

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
CH_BITS, 2, width of channel index; ceil(log2(NUM_CH))
DATA_BITS, 8, byte width; must match uart_tx DATA_BITS
LOCK_TIMEOUT, 1000, clk cycles a locked channel may idle between bytes before its lock is dropped

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
req_valid  input  NUM_CH  per-channel byte available
req_data  input  NUM_CH*DATA_BITS  per-channel byte; channel i occupies bits [i*DATA_BITS +: DATA_BITS]
req_last  input  NUM_CH  byte is last of a packet (releases lock)
req_ready  output  NUM_CH  one-hot accept strobe; byte transferred when req_valid[i] & req_ready[i]
tx_start  output  1  one-cycle start pulse to uart_tx
tx_data  output  DATA_BITS  byte to uart_tx data_in
tx_done_tick  input  1  uart_tx stop bit complete
busy  output  1  high while any channel holds a grant
grant_ch  output  CH_BITS  currently or most recently granted channel

Behaviour:
- Reset values: tx_start=0, req_ready=0, tx_data=0, busy=0, grant_ch=0. Round-robin pointer last_ch=NUM_CH-1, so channel 0 has first priority. Lock timer=0. FSM=IDLE.
- Reset mid-operation aborts everything: no further tx_start, lock dropped. A byte already in uart_tx is not tracked.
- FSM states: IDLE, START, WAIT_DONE, HOLD.
- IDLE:
  - If any req_valid, select the first valid channel c searching (last_ch+1) mod NUM_CH upward with wrap.
  - req_ready[c]=1 combinationally in this same cycle.
  - Register tx_data<=req_data[c], last_reg<=req_last[c], grant_ch<=c, busy<=1, then go to START.
  - If no req_valid, req_ready=0 and stay in IDLE.
- START: tx_start=1 for exactly one cycle, tx_data held, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_done_tick; tx_data stays stable throughout.
  - On the tick with last_reg=1: last_ch<=grant_ch, busy<=0, go to IDLE.
  - On the tick with last_reg=0: lock timer<=0, go to HOLD.
- HOLD (lock held by grant_ch):
  - If req_valid[grant_ch], assert req_ready[grant_ch] this cycle, latch data/last, go to START.
  - Valid bytes from other channels are ignored.
  - Otherwise the timer increments. When timer==LOCK_TIMEOUT-1 with no valid: last_ch<=grant_ch, busy<=0, go to IDLE.
  - A valid byte arriving on the timeout cycle wins; the timeout does not fire.
- Latency:
  - Valid on an idle arbiter: accept in cycle 0, tx_start in cycle 1.
  - After tx_done_tick of a non-last byte with the next byte already valid: HOLD accept 1 cycle later, tx_start 2 cycles after the tick. uart_tx is already back in IDLE.
  - After a last byte: IDLE re-arbitrates the next cycle, tx_start 2 cycles after the tick.
- At most one req_ready bit is high in any cycle. req_ready is never high outside IDLE/HOLD.
- tx_done_tick outside WAIT_DONE is ignored.
- Fairness: the pointer advances only on lock release, so each packet is sent atomically and channels rotate per packet.
- Single-channel case: a channel re-requesting after its release may be re-granted only if no other channel is valid.
- Lock timer width is ceil(log2(LOCK_TIMEOUT+1)). It saturates and never wraps.

Test Plan:
- Single byte: ch2 sends 0xA5 with last=1 after reset -> req_ready[2] same cycle; tx_start 1 cycle later with tx_data=0xA5; busy falls the cycle after tx_done_tick; grant_ch=2.
- Round-robin: all 4 channels valid continuously, every byte last=1 -> grant order 0,1,2,3,0; exactly one tx_start per tx_done_tick.
- Packet lock: ch1 sends 0x11,0x22,0x33 (last on 0x33) while ch0 and ch3 are valid -> three consecutive ch1 bytes, then ch3 granted (pointer after 1 reaches 3 before 0? no: 2,3,0 order, so ch3).
- Lock timeout (LOCK_TIMEOUT=8): ch0 sends 0x55 with last=0, then drops valid; ch1 valid -> ch0 lock released exactly 8 cycles after entering HOLD; ch1 granted the following cycle.
- Timeout race: ch0 valid asserted exactly on the timeout cycle -> ch0 byte accepted, lock retained, no grant to ch1.
- Reset mid-packet: assert reset during WAIT_DONE -> tx_start, req_ready and busy all 0 next cycle; after release, ch0 has priority again.
